// File: rtl/inst_encoder_if.sv
// rtl/inst_encoder_if.sv - handshake bundle between a field producer and inst_encoder
//
// Purpose: carries the decoded-field input stream, the encoded-word output
// stream and the accepted-word count as one bundle.
// Modports:
//   master - producer/consumer side: drives in_* fields, in_valid, out_ready;
//            observes in_ready, out_valid, out_inst, out_addr, out_err, count.
//   slave  - inst_encoder side (the reverse directions).
interface inst_encoder_if #(
   parameter int ADDR_W = 14
);
   logic              in_valid;
   logic              in_ready;
   logic [2:0]        in_fmt;
   logic [6:0]        in_opcode;
   logic [2:0]        in_funct3;
   logic [6:0]        in_funct7;
   logic [4:0]        in_rd;
   logic [4:0]        in_rs1;
   logic [4:0]        in_rs2;
   logic [31:0]       in_imm;
   logic              out_valid;
   logic              out_ready;
   logic [31:0]       out_inst;
   logic [ADDR_W-1:0] out_addr;
   logic              out_err;
   logic [ADDR_W:0]   count;

   modport master (
      output in_valid, in_fmt, in_opcode, in_funct3, in_funct7,
             in_rd, in_rs1, in_rs2, in_imm, out_ready,
      input  in_ready, out_valid, out_inst, out_addr, out_err, count
   );

   modport slave (
      input  in_valid, in_fmt, in_opcode, in_funct3, in_funct7,
             in_rd, in_rs1, in_rs2, in_imm, out_ready,
      output in_ready, out_valid, out_inst, out_addr, out_err, count
   );
endinterface

// File: rtl/inst_encoder.sv
// rtl/inst_encoder.sv - RV32I field-to-word encoder with 2-entry output FIFO
//
// Purpose: packs decoded RV32I fields into 32-bit instruction words, tags
// each with a sequential word address and queues it in a 2-deep FIFO.
// Illegal field combinations are stored as NOP (addi x0,x0,0) with err set.
// Ports:
//   clk   - clock, rising edge
//   rst   - synchronous active-high reset
//   start - synchronous flush of FIFO, address counter and count
//   bus   - inst_encoder_if.slave: input field stream, output word stream, count
module inst_encoder #(
   parameter int                ADDR_W    = 14,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
   input logic           clk,
   input logic           rst,
   input logic           start,
   inst_encoder_if.slave bus
);
   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic [1:0] {EMPTY, ONE, FULL} occ_t;

   occ_t              state, state_next;
   logic              rd_ptr, wr_ptr;
   logic [31:0]       fifo_inst [2];
   logic [ADDR_W-1:0] fifo_addr [2];
   logic              fifo_err  [2];
   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W:0]   count_q;
   logic [31:0]       enc_word;
   logic              enc_err;
   logic              push, pop;

   // ---------------- field encoder ----------------
   always_comb begin
      logic [31:0] imm;
      logic        shift_op;
      imm      = bus.in_imm;
      enc_word = NOP;
      enc_err  = 1'b0;
      // Shift-immediate forms live under the I format but use funct7 + shamt.
      shift_op = (bus.in_opcode == 7'b0010011) &&
                 ((bus.in_funct3 == 3'b001) || (bus.in_funct3 == 3'b101));
      case (bus.in_fmt)
         3'd0: enc_word = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3,
                           bus.in_rd, bus.in_opcode};
         3'd1, 3'd6: begin
            if (shift_op && (bus.in_fmt == 3'd1)) begin
               enc_word = {bus.in_funct7, imm[4:0], bus.in_rs1, bus.in_funct3,
                           bus.in_rd, bus.in_opcode};
               enc_err  = |imm[31:5];
            end else begin
               enc_word = {imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode};
               enc_err  = !((&imm[31:11]) || !(|imm[31:11]));
            end
         end
         3'd2: begin
            enc_word = {imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                        imm[4:0], bus.in_opcode};
            enc_err  = !((&imm[31:11]) || !(|imm[31:11]));
         end
         3'd3: begin
            enc_word = {imm[12], imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                        imm[4:1], imm[11], bus.in_opcode};
            enc_err  = !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
         end
         3'd4: begin
            enc_word = {imm[31:12], bus.in_rd, bus.in_opcode};
            enc_err  = |imm[11:0];
         end
         3'd5: begin
            enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], bus.in_rd, bus.in_opcode};
            enc_err  = !((&imm[31:20]) || !(|imm[31:20])) || imm[0];
         end
         default: enc_err = 1'b1;
      endcase
      if (enc_err) enc_word = NOP;
   end

   // ---------------- handshake ----------------
   assign bus.in_ready  = !rst && !start && (state != FULL);
   assign bus.out_valid = (state != EMPTY);
   assign push          = bus.in_valid && bus.in_ready;
   assign pop           = bus.out_valid && bus.out_ready;

   assign bus.out_inst = fifo_inst[rd_ptr];
   assign bus.out_addr = fifo_addr[rd_ptr];
   assign bus.out_err  = fifo_err[rd_ptr];
   assign bus.count    = count_q;

   // ---------------- occupancy FSM ----------------
   always_ff @(posedge clk) begin
      if (rst) state <= EMPTY;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      if (start) begin
         state_next = EMPTY;
      end else begin
         case (state)
            EMPTY:   if (push) state_next = ONE;
            ONE: begin
               if (push && !pop)      state_next = FULL;
               else if (pop && !push) state_next = EMPTY;
            end
            FULL:    if (pop) state_next = ONE;
            default: state_next = EMPTY;
         endcase
      end
   end

   // ---------------- storage, pointers, address and count ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr  <= 1'b0;
         wr_ptr  <= 1'b0;
         addr_q  <= BASE_ADDR;
         count_q <= '0;
         for (int i = 0; i < 2; i++) begin
            fifo_inst[i] <= '0;
            fifo_addr[i] <= '0;
            fifo_err[i]  <= 1'b0;
         end
      end else if (start) begin
         rd_ptr  <= 1'b0;
         wr_ptr  <= 1'b0;
         addr_q  <= BASE_ADDR;
         count_q <= '0;
      end else begin
         if (push) begin
            fifo_inst[wr_ptr] <= enc_word;
            fifo_addr[wr_ptr] <= addr_q;
            fifo_err[wr_ptr]  <= enc_err;
            wr_ptr            <= ~wr_ptr;
            addr_q            <= addr_q + ADDR_W'(1);
            if (!(&count_q)) count_q <= count_q + (ADDR_W+1)'(1);
         end
         // With one entry, push+pop toggles both pointers so the new word is head.
         if (pop) rd_ptr <= ~rd_ptr;
      end
   end
endmodule

// File: doc/inst_encoder.md
# inst_encoder

RV32I instruction encoder: the inverse of the pipeline's decode/control path. It accepts decoded instruction fields over a valid/ready handshake and packs them into 32-bit instruction words. Each word is tagged with a sequential word address and queued in a 2-entry output FIFO for the instruction-memory loader and self-test sequencer. Illegal field combinations are replaced by a NOP and flagged.

## Interface
- ADDR_W, 14: width of the word-address counter.
- BASE_ADDR, 0: word address loaded on reset and on `start`.
---
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  synchronous pulse: flushes the FIFO and reloads the address counter and `count`.
- in_valid  in  1  input fields are valid.
- in_ready  out  1  block can accept; combinational, = !rst && !start && (occupancy < 2).
- in_fmt  in  3  format: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6=CSR, 7=illegal.
- in_opcode  in  7  opcode[6:0].
- in_funct3  in  3  funct3.
- in_funct7  in  7  funct7 (R format, and I-format shifts).
- in_rd, in_rs1, in_rs2  in  5 each  register fields; for CSR immediate forms, in_rs1 carries uimm.
- in_imm  in  32  byte-offset/immediate, sign-extended, unencoded.
- out_valid  out  1  FIFO head is valid (occupancy > 0).
- out_ready  in  1  consumer accepts the head.
- out_inst  out  32  encoded word at the FIFO head.
- out_addr  out  ADDR_W  word address of the head.
- out_err  out  1  head word was illegal and was replaced by a NOP.
- count  out  ADDR_W+1  number of words accepted since reset/start; saturates at all-ones.

## Operation
- Accept when in_valid && in_ready. The encoded word, current address and error flag are pushed to the FIFO tail. The address counter then increments modulo 2^ADDR_W and `count` increments, saturating at all-ones.
- Pop when out_valid && out_ready. Order is strictly FIFO.
- Encoding, MSB to LSB:
  - R: funct7|rs2|rs1|funct3|rd|opcode.
  - I: imm[11:0]|rs1|funct3|rd|opcode.
  - I-shift (opcode 0010011, funct3 001 or 101): funct7|imm[4:0]|rs1|funct3|rd|opcode.
  - S: imm[11:5]|rs2|rs1|funct3|imm[4:0]|opcode.
  - B: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|opcode.
  - U: imm[31:12]|rd|opcode.
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|opcode.
  - CSR: imm[11:0] is the CSR address; layout as I, with the rs1 field carrying rs1 or uimm.
- Error conditions. Any one of these sets the error flag:
  - fmt = 7.
  - I/S/CSR: imm[31:11] is not all-equal.
  - B: imm[31:12] is not all-equal, or imm[0] = 1.
  - J: imm[31:20] is not all-equal, or imm[0] = 1.
  - U: imm[11:0] != 0.
  - I-shift: imm[31:5] != 0.
- An errored word is stored as 32'h0000_0013 with err = 1. It still consumes an address and counts.
- FIFO occupancy states are EMPTY (0), ONE (1) and FULL (2):
  - Push only: occupancy +1.
  - Pop only: occupancy -1.
  - Push and pop in ONE: stays ONE; the new word becomes the head next cycle.
  - In FULL, in_ready = 0, so a simultaneous push is impossible.
- `start`: next cycle occupancy = 0, address = BASE_ADDR, count = 0. An input presented in the `start` cycle is not accepted.

## Timing
- Reset values: out_valid=0, out_inst=0, out_addr=0, out_err=0, count=0, internal address=BASE_ADDR, occupancy=0. in_ready=0 while rst=1, and 1 in the first cycle after reset.
- Latency: a word accepted at edge N is visible at out_* after edge N with out_valid=1, i.e. 1 cycle; there is no combinational input-to-output path.
- out_inst, out_addr and out_err are held stable while out_valid && !out_ready.
- rst or start asserted mid-stream discards all queued words at that edge; no partial output.
- Address wrap: after address 2^ADDR_W-1 the next word gets address 0.

## Test plan
- addi x1,x0,5 (fmt=1, op=0010011, f3=000, rd=1, rs1=0, imm=5) -> out_inst=0x00500093, out_addr=BASE_ADDR, out_err=0, 1 cycle after acceptance.
- sub x3,x1,x2 (fmt=0, f7=0100000, op=0110011) followed by beq x1,x2,-8 (fmt=3, op=1100011, imm=0xFFFFFFF8) -> 0x402081B3 then 0xFE208CE3, at consecutive addresses.
- jal x1,+2048 (fmt=5, op=1101111, rd=1, imm=0x800) -> 0x001000EF. Same with imm=0x801 -> 0x00000013, out_err=1.
- out_ready=0, three back-to-back inputs -> first two accepted at addresses 0 and 1; in_ready=0 on the third. Raise out_ready -> words pop in order; the third word is accepted and gets address 2.
- lui with imm=0x12345001 -> NOP with err=1, count advances. sw with imm=2048 -> NOP with err=1.
- ADDR_W=2: push 5 words -> addresses 0,1,2,3,0. Then assert start with 2 words queued -> out_valid=0 next cycle, next word at BASE_ADDR, count=1.
